rd_pattern_checker: RTL and testbench

- Read-side counterpart of the 32-entry x 512-bit pattern ROM used by the DDR3 testbench.
- Consumes the read-back data stream returned from DDR3 via a valid/ready handshake and drives the pattern ROM address itself.
- Compares each returned word against the expected ROM pattern and reports pass/fail, error count, first failing index and a per-word mismatch mask.
- Sits between the memory-controller read-data path and the test sequencer.

---
 rtl/rd_pattern_checker.sv | 149 ++++++++++++++
 tb/tb_rd_pattern_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_pattern_checker.sv
// Read-back checker: walks the pattern ROM address, compares each returned DDR3 word
// against the expected pattern and accumulates pass/fail status for the sequencer.
module rd_pattern_checker #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              err_flag,
  output logic [DEPTH-1:0]  mismatch_mask
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StDone} state_e;

  localparam logic [ADDR_W:0] DepthLen = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic                err_flag_q, err_flag_d;
  logic [DEPTH-1:0]    mismatch_mask_q, mismatch_mask_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                accept;
  logic                mismatch;
  logic                last_word;

  assign accept    = (state_q == StWait) && rd_valid;
  assign mismatch  = (rd_data != exp_data);
  assign last_word = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));

  always_comb begin
    state_d         = state_q;
    exp_addr_d      = exp_addr_q;
    idx_d           = idx_q;
    len_d           = len_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    err_flag_d      = err_flag_q;
    mismatch_mask_d = mismatch_mask_q;
    busy_d          = busy_q;
    done_d          = done_q;
    pass_d          = pass_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          len_d           = (num_words > DepthLen) ? DepthLen : num_words;
          err_cnt_d       = '0;
          first_err_idx_d = '0;
          mismatch_mask_d = '0;
          err_flag_d      = 1'b0;
          idx_d           = '0;
          exp_addr_d      = '0;
          if (num_words == '0) begin
            // Empty run completes immediately as a trivial pass.
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = StFetch;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        if (accept) begin
          if (mismatch) begin
            err_cnt_d              = err_cnt_q + (ADDR_W+1)'(1);
            mismatch_mask_d[idx_q] = 1'b1;
            err_flag_d             = 1'b1;
            if (!err_flag_q) first_err_idx_d = idx_q;
          end
          if (last_word) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !(err_flag_q || mismatch);
          end else begin
            idx_d      = idx_q + ADDR_W'(1);
            exp_addr_d = idx_q + ADDR_W'(1);
            state_d    = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      exp_addr_q      <= '0;
      idx_q           <= '0;
      len_q           <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      err_flag_q      <= 1'b0;
      mismatch_mask_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      exp_addr_q      <= exp_addr_d;
      idx_q           <= idx_d;
      len_q           <= len_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      err_flag_q      <= err_flag_d;
      mismatch_mask_q <= mismatch_mask_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign exp_addr      = exp_addr_q;
  assign rd_ready      = (state_q == StWait);
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign err_flag      = err_flag_q;
  assign mismatch_mask = mismatch_mask_q;

endmodule

// File: tb/tb_rd_pattern_checker.sv
// Bench for rd_pattern_checker: registered ROM model, read-back driver with optional
// error injection and backpressure, table-driven runs plus randomized runs.
module tb_rd_pattern_checker;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   num_words;
  logic [4:0]   exp_addr;
  logic [511:0] exp_data;
  logic         rd_valid;
  logic [511:0] rd_data;
  logic         rd_ready;
  logic         busy, done, pass, err_flag;
  logic [5:0]   err_cnt;
  logic [4:0]   first_err_idx;
  logic [31:0]  mismatch_mask;

  rd_pattern_checker dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_words    (num_words),
    .exp_addr     (exp_addr),
    .exp_data     (exp_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .err_flag     (err_flag),
    .mismatch_mask(mismatch_mask)
  );

  initial forever #5 clk = ~clk;

  logic [511:0] rom  [32];
  logic [511:0] flip [32];

  always @(posedge clk) exp_data <= rom[exp_addr];

  int checks = 0;
  int errors = 0;

  // Per-run observations from the driver
  int acc_n, addr_bad, done_cyc, ready_cyc, last_edge;
  bit aborted;

  // Reference model results
  int          m_len, m_err, m_first;
  logic [31:0] m_mask;
  bit          m_pass;

  typedef struct {
    int          num;
    int          pct;
    int          fa_w, fa_b, fb_w, fb_b;
    int          mid;
    int          exp_err;
    int          exp_first;
    logic [31:0] exp_mask;
    bit          exp_pass;
    int          exp_acc;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic void model(input int num);
    m_len   = (num > 32) ? 32 : num;
    m_err   = 0;
    m_first = 0;
    m_mask  = '0;
    for (int i = 0; i < m_len; i++) begin
      if (flip[i] != '0) begin
        if (m_err == 0) m_first = i;
        m_err++;
        m_mask[i] = 1'b1;
      end
    end
    m_pass = (m_err == 0);
  endfunction

  task automatic clear_flips();
    for (int i = 0; i < 32; i++) flip[i] = '0;
  endtask

  // Drives one run; cyc counts posedges since the edge that sampled start.
  task automatic do_run(input int num, input int pct, input int mid_word, input int abort_word);
    int word;
    bit v, mid_done;
    acc_n = 0; addr_bad = 0; done_cyc = -1; ready_cyc = -1; last_edge = 0; aborted = 0;
    word = 0; mid_done = 0;
    @(negedge clk);
    start = 1'b1;
    num_words = 6'(num);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_word >= 0 && word == abort_word) begin
        rd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        aborted = 1;
        break;
      end
      if (rd_ready && ready_cyc < 0) ready_cyc = cyc;
      v = ($urandom_range(99) < pct);
      rd_valid = v;
      if (rd_ready) rd_data = rom[word % 32] ^ flip[word % 32];
      else rd_data = {16{$urandom}};
      if (rd_ready && v) begin
        if (exp_addr != 5'(word)) addr_bad++;
        word++;
        last_edge = cyc + 1;
      end
      if (mid_word >= 0 && !mid_done && word == mid_word) begin
        start = 1'b1;
        num_words = 6'd2;
        mid_done = 1;
      end
    end
    if (done_cyc < 0 && !aborted) chk("run_timeout", 64'(done_cyc), 64'd0);
    rd_valid = 1'b0;
    start = 1'b0;
    acc_n = word;
  endtask

  task automatic check_result(input string tag, input int len, input int e_err, input int e_first,
                              input logic [31:0] e_mask, input bit e_pass);
    bit ready_in_hold;
    chk({tag, "_acc"}, 64'(acc_n), 64'(len));
    chk({tag, "_addr_seq"}, 64'(addr_bad), 64'd0);
    chk({tag, "_done_lat"}, 64'(done_cyc), (len == 0) ? 64'd0 : 64'(last_edge));
    chk({tag, "_ready_lat"}, 64'(ready_cyc), (len == 0) ? -64'sd1 : 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    chk({tag, "_first"}, 64'(first_err_idx), 64'(e_first));
    chk({tag, "_mask"}, 64'(mismatch_mask), 64'(e_mask));
    chk({tag, "_pass_flag_busy"}, {61'd0, pass, err_flag, busy}, {61'd0, e_pass, e_err != 0, 1'b0});
    ready_in_hold = 0;
    for (int k = 0; k < 3; k++) begin
      rd_valid = 1'b1;
      rd_data  = {16{$urandom}};
      @(negedge clk);
      if (rd_ready) ready_in_hold = 1;
    end
    rd_valid = 1'b0;
    chk({tag, "_hold"}, {25'd0, ready_in_hold, done, pass, err_cnt, mismatch_mask},
        {25'd0, 1'b0, 1'b1, e_pass, 6'(e_err), e_mask});
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 16; j++) rom[i][j*32 +: 32] = $urandom;
    rom[0] = {16{32'hDEAD_BEEF}};
    clear_flips();

    vecs[0] = '{32, 100, -1, 0, -1, 0,   -1, 0, 0,  32'h0,         1'b1, 32, 64};
    vecs[1] = '{10, 100,  3, 0,  7, 511, -1, 2, 3,  32'h0000_0088, 1'b0, 10, -1};
    vecs[2] = '{8,  50,  -1, 0, -1, 0,   -1, 0, 0,  32'h0,         1'b1, 8,  -1};
    vecs[3] = '{0,  100, -1, 0, -1, 0,   -1, 0, 0,  32'h0,         1'b1, 0,  0};
    vecs[4] = '{1,  100, -1, 0, -1, 0,   -1, 0, 0,  32'h0,         1'b1, 1,  2};
    vecs[5] = '{40, 100, 31, 100, -1, 0, -1, 1, 31, 32'h8000_0000, 1'b0, 32, 64};
    vecs[6] = '{16, 100,  9, 5, -1, 0,    4, 1, 9,  32'h0000_0200, 1'b0, 16, 32};

    reset = 1'b0; start = 1'b0; num_words = '0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {11'd0, exp_addr, rd_ready, busy, done, pass, err_cnt, first_err_idx,
                       err_flag, mismatch_mask}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      clear_flips();
      if (vecs[i].fa_w >= 0) flip[vecs[i].fa_w][vecs[i].fa_b] = 1'b1;
      if (vecs[i].fb_w >= 0) flip[vecs[i].fb_w][vecs[i].fb_b] = 1'b1;
      do_run(vecs[i].num, vecs[i].pct, vecs[i].mid, -1);
      check_result($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_err, vecs[i].exp_first,
                   vecs[i].exp_mask, vecs[i].exp_pass);
      if (vecs[i].exp_done_cyc >= 0)
        chk($sformatf("vec%0d_done_cyc", i), 64'(done_cyc), 64'(vecs[i].exp_done_cyc));
    end

    // Reset after five accepted words, one of which mismatched
    clear_flips();
    flip[2][17] = 1'b1;
    do_run(10, 100, -1, 5);
    chk("abort_taken", 64'(aborted), 64'd1);
    chk("abort_outs", {11'd0, exp_addr, rd_ready, busy, done, pass, err_cnt, first_err_idx,
                       err_flag, mismatch_mask}, 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_idle", {61'd0, rd_ready, busy, done}, 64'd0);
    clear_flips();
    do_run(4, 100, -1, -1);
    check_result("after_abort", 4, 0, 0, 32'h0, 1'b1);

    // Randomized runs against the reference model
    for (int r = 0; r < 8; r++) begin
      int num;
      clear_flips();
      for (int i = 0; i < 32; i++)
        if ($urandom_range(99) < 20) flip[i][$urandom_range(511)] = 1'b1;
      num = $urandom_range(40);
      model(num);
      do_run(num, $urandom_range(25, 100), -1, -1);
      check_result($sformatf("rnd%0d", r), m_len, m_err, m_first, m_mask, m_pass);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
